// File: rtl/psg_bus_writer.sv
// psg_bus_writer: serializes register write requests into strobed PSG latch/data bytes, skipping redundant tone high bytes
module psg_bus_writer #(
  parameter int WE_CYCLES  = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_reg,
  input  logic [9:0] req_value,
  input  logic       flush_shadow,
  output logic [7:0] psg_data,
  output logic       psg_we_n,
  output logic       busy
);
  localparam int MAXC = (WE_CYCLES > GAP_CYCLES) ? WE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_data;
  logic [5:0]      r_hi;
  logic            r_h_pend;
  logic [1:0]      r_ch;
  logic [2:0][5:0] r_sh;
  logic [2:0]      r_sh_v;
  logic            w_accept, w_tone, w_hit, w_last, w_load_h, w_sh_v;
  logic [1:0]      w_ch;
  logic [5:0]      w_sh;
  logic [7:0]      w_latch;
  assign w_accept = req_valid && req_ready;
  assign w_tone   = !req_reg[0] && req_reg != 3'b110;
  assign w_ch     = req_reg[2:1];
  assign w_sh     = (w_ch == 2'd0) ? r_sh[0] : (w_ch == 2'd1) ? r_sh[1] : r_sh[2];
  assign w_sh_v   = (w_ch == 2'd0) ? r_sh_v[0] : (w_ch == 2'd1) ? r_sh_v[1] : r_sh_v[2];
  // a flush in the accept cycle must force the high byte out
  assign w_hit    = w_sh_v && w_sh == req_value[9:4] && !flush_shadow;
  assign w_latch  = (req_reg == 3'b110) ? {5'b11100, req_value[2:0]} : {1'b1, req_reg, req_value[3:0]};
  assign w_last   = (r_state == STROBE && r_cnt == '0 && GAP_CYCLES == 0) || (r_state == GAP && r_cnt == '0);
  assign w_load_h = w_last && r_h_pend;
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE)  ? (w_accept ? SETUP : IDLE) :
             (r_state == SETUP) ? STROBE :
             w_last             ? (r_h_pend ? SETUP : IDLE) :
             (r_state == STROBE && r_cnt == '0) ? GAP : r_state;
  end
  always_comb begin
    psg_we_n  = r_state != STROBE;
    psg_data  = r_data;
    busy      = r_state != IDLE;
    req_ready = r_state == IDLE && rst_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_next != r_state)
      r_cnt <= (w_next == STROBE) ? CW'(WE_CYCLES - 1) :
               (w_next == GAP)    ? CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0) : '0;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_hi     <= '0;
      r_h_pend <= 1'b0;
      r_ch     <= '0;
      r_sh     <= '0;
      r_sh_v   <= '0;
    end else begin
      if (w_accept) begin
        r_data   <= w_latch;
        r_hi     <= req_value[9:4];
        r_h_pend <= w_tone && !w_hit;
        r_ch     <= w_ch;
      end else if (w_load_h) begin
        r_data   <= {2'b00, r_hi};
        r_h_pend <= 1'b0;
      end
      for (int c = 0; c < 3; c++)
        if (w_load_h && r_ch == c[1:0]) begin
          r_sh[c]   <= r_hi;
          r_sh_v[c] <= 1'b1;
        end
      if (flush_shadow) r_sh_v <= '0;
    end
  end
endmodule

// File: tb/tb_psg_bus_writer.sv
// tb_psg_bus_writer: drives three parameterizations with directed and random writes against a byte-level model
module tb_psg_bus_writer;
  localparam int WEP [3] = '{2, 1, 5};
  localparam int GP  [3] = '{1, 0, 3};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0]      rst_n, valid, ready, flush, we_n, busy;
  logic [2:0][2:0] rreg;
  logic [2:0][9:0] rval;
  logic [2:0][7:0] pdata;
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gi
      psg_bus_writer #(.WE_CYCLES(WEP[g]), .GAP_CYCLES(GP[g])) u (
        .clk(clk), .rst_n(rst_n[g]), .req_valid(valid[g]), .req_ready(ready[g]),
        .req_reg(rreg[g]), .req_value(rval[g]), .flush_shadow(flush[g]),
        .psg_data(pdata[g]), .psg_we_n(we_n[g]), .busy(busy[g]));
    end
  endgenerate
  logic [7:0] obs [3][256];
  int         nobs [3] = '{0, 0, 0};
  logic [2:0] pw = '1;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      if (!we_n[i] && pw[i]) begin
        obs[i][nobs[i] % 256] <= pdata[i];
        nobs[i] <= nobs[i] + 1;
      end
    pw <= we_n;
  end
  logic [5:0] msh [3][3];
  logic [2:0] mshv [3];
  int nassert = 0, nfail = 0;
  task automatic chk(input string tag, input int o, input int e);
    nassert++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  // expected bytes for a request accepted now; shadows updated eagerly
  task automatic model(input int i, input logic [2:0] r, input logic [9:0] v, input logic f,
                       output int ne, output logic [7:0] b0, output logic [7:0] b1);
    int ch;
    if (f) mshv[i] = '0;
    b1 = {2'b00, v[9:4]};
    ne = 1;
    if (r == 3'b110) b0 = {5'b11100, v[2:0]};
    else begin
      b0 = {1'b1, r, v[3:0]};
      if (!r[0]) begin
        ch = int'(r[2:1]);
        if (!(mshv[i][ch] && msh[i][ch] == v[9:4])) begin
          ne = 2;
          msh[i][ch] = v[9:4];
          mshv[i][ch] = 1'b1;
        end
      end
    end
  endtask
  task automatic chk_rst(input int i);
    chk("rst_we_n", int'(we_n[i]), 1);
    chk("rst_data", int'(pdata[i]), 0);
    chk("rst_ready", int'(ready[i]), 0);
    chk("rst_busy", int'(busy[i]), 0);
  endtask
  task automatic wait_ready(input int i);
    int k = 0;
    while (!ready[i] && k < 60) begin @(negedge clk); k++; end
    chk("ready_wait", int'(ready[i]), 1);
  endtask
  task automatic flush_pulse(input int i);
    flush[i] = 1'b1;
    @(negedge clk);
    flush[i] = 1'b0;
    mshv[i] = '0;
  endtask
  task automatic do_req(input int i, input logic [2:0] r, input logic [9:0] v, input logic f);
    int ne, base, occ, low, si, nst;
    logic [7:0] e [2];
    logic bad, pwl;
    logic [7:0] pdl;
    model(i, r, v, f, ne, e[0], e[1]);
    wait_ready(i);
    valid[i] = 1'b1; rreg[i] = r; rval[i] = v; flush[i] = f;
    base = nobs[i];
    @(negedge clk);
    valid[i] = 1'b0; flush[i] = 1'b0; rreg[i] = 3'($urandom); rval[i] = 10'($urandom);
    occ = 0; low = 0; si = -1; nst = 0; bad = 1'b0; pwl = 1'b1; pdl = pdata[i];
    while (!ready[i] && occ < 100) begin
      if (!we_n[i] && pwl) begin
        si++; nst++;
        if (si >= ne || pdl !== e[si]) bad = 1'b1;
      end
      if (!we_n[i]) begin
        low++;
        if (si < 0 || si >= ne || pdata[i] !== e[si]) bad = 1'b1;
      end else if (si >= 0 && si < ne && !(pdata[i] === e[si] || (si + 1 < ne && pdata[i] === e[1])))
        bad = 1'b1;
      pwl = we_n[i]; pdl = pdata[i];
      occ++;
      @(negedge clk);
    end
    chk("occupancy", occ, ne * (1 + WEP[i] + GP[i]));
    chk("strobes", nst, ne);
    chk("low_cycles", low, ne * WEP[i]);
    chk("data_stable", int'(bad), 0);
    chk("nbytes", nobs[i] - base, ne);
    for (int j = 0; j < ne; j++) chk("byte", int'(obs[i][(base + j) % 256]), int'(e[j]));
  endtask
  initial begin
    int base, nexp, ne, nacc;
    logic prev_acc;
    logic [7:0] exq [128];
    logic [7:0] b0, b1;
    logic [9:0] v;
    rst_n = '0; valid = '0; flush = '0; rreg = '0; rval = '0;
    for (int i = 0; i < 3; i++) mshv[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_rst(i);
    rst_n = '1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("ready_after_rst", int'(ready[i]), 1);
    do_req(0, 3'b000, 10'h3A5, 1'b0);
    do_req(0, 3'b000, 10'h3A7, 1'b0);
    flush_pulse(0);
    do_req(0, 3'b000, 10'h3A7, 1'b0);
    do_req(0, 3'b010, 10'h155, 1'b0);
    do_req(0, 3'b011, 10'h005, 1'b0);
    do_req(0, 3'b110, 10'h3FE, 1'b0);
    do_req(0, 3'b010, 10'h15A, 1'b0);
    do_req(0, 3'b000, 10'h3A7, 1'b1);
    do_req(1, 3'b000, 10'h3A5, 1'b0);
    do_req(1, 3'b000, 10'h3A7, 1'b0);
    do_req(2, 3'b000, 10'h3A5, 1'b0);
    do_req(2, 3'b011, 10'h005, 1'b0);
    for (int n = 0; n < 20; n++)
      for (int i = 0; i < 3; i++) begin
        v = {6'($urandom_range(0, 2)), 4'($urandom)};
        do_req(i, 3'($urandom_range(0, 7)), v, $urandom_range(0, 7) == 0);
        if ($urandom_range(0, 9) == 0) flush_pulse(i);
      end
    wait_ready(0);
    valid[0] = 1'b1; rreg[0] = 3'b100; rval[0] = 10'h2F1;
    @(negedge clk);
    valid[0] = 1'b0;
    @(negedge clk);
    chk("strobe_before_rst", int'(we_n[0]), 0);
    rst_n[0] = 1'b0;
    @(negedge clk);
    chk_rst(0);
    mshv[0] = '0;
    rst_n[0] = 1'b1;
    base = nobs[0];
    repeat (12) @(negedge clk);
    chk("no_h_after_rst", nobs[0] - base, 0);
    chk("idle_after_rst", int'(ready[0]), 1);
    do_req(0, 3'b100, 10'h2F1, 1'b0);
    base = nobs[0]; nexp = 0; nacc = 0; prev_acc = 1'b0;
    for (int t = 0; t < 60; t++) begin
      rreg[0] = 3'($urandom_range(0, 7));
      rval[0] = {6'($urandom_range(0, 2)), 4'($urandom)};
      valid[0] = 1'b1;
      if (prev_acc) chk("no_back_to_back", int'(ready[0]), 0);
      prev_acc = ready[0];
      if (ready[0]) begin
        model(0, rreg[0], rval[0], 1'b0, ne, b0, b1);
        exq[nexp] = b0; nexp++;
        if (ne == 2) begin exq[nexp] = b1; nexp++; end
        nacc++;
      end
      @(negedge clk);
    end
    valid[0] = 1'b0;
    wait_ready(0);
    chk("holdoff_accepts_min", int'(nacc >= 7), 1);
    chk("holdoff_nbytes", nobs[0] - base, nexp);
    for (int j = 0; j < nexp; j++) chk("holdoff_byte", int'(obs[0][(base + j) % 256]), int'(exq[j]));
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/psg_bus_writer.md
# psg_bus_writer

Host-side write-bus driver for the SN76489-compatible PSG core. It accepts register-level write requests over a valid/ready handshake and serializes each one into the PSG byte protocol: a latch/data byte, plus an optional second data byte. Each byte is presented on an 8-bit data bus and qualified by an active-low write strobe. The block sits between a sequencer (music player, CPU bridge) and the PSG's `ui_in` / `uio_in[0]` pins. It also suppresses redundant tone high-byte writes through per-channel shadow registers.

## Interface
Parameters:
- `WE_CYCLES`, 2: width of the `psg_we_n` low pulse, in clk cycles; legal range ≥1.
- `GAP_CYCLES`, 1: cycles with `psg_we_n` high after each strobe, before the next byte or before returning to idle; legal range ≥0.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset; synchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_reg`  in  3  PSG register select:
  - 000 / 010 / 100: tone 0 / 1 / 2 frequency.
  - 110: noise control.
  - x x1: attenuation of channel `req_reg[2:1]`.
- `req_value`  in  10  register value; the low bits are used per register type.
- `flush_shadow`  in  1  invalidate all tone shadows.
- `psg_data`  out  8  byte to the PSG data inputs.
- `psg_we_n`  out  1  active-low write enable to the PSG.
- `busy`  out  1  high whenever not in IDLE.

## Operation
- Handshake:
  - A request is accepted on a rising edge where `req_valid && req_ready`.
  - `req_ready` is high only in IDLE and never during reset.
  - `req_reg` and `req_value` are captured at acceptance; later changes on those inputs are ignored.
- Byte encoding, latch byte L = {1, req_reg, low nibble}:
  - Tone: L = {1, reg, value[3:0]}; high byte H = {00, value[9:4]}.
  - Noise (110): L = {1, 110, 0, value[2:0]}; `value[9:3]` is ignored; no H.
  - Attenuation: L = {1, reg, value[3:0]}; `value[9:4]` is ignored; no H.
- Tone shadows: three 6-bit registers, each with a valid flag.
  - H is sent unless the channel's shadow is valid and equals `value[9:4]`.
  - When H is sent, the shadow is loaded and marked valid at the edge that enters H's SETUP.
- `flush_shadow` clears all three valid flags at the next edge, in any state.
  - If it is asserted in the same cycle a tone request is accepted, that request sends H.
- FSM states: IDLE, SETUP, STROBE, GAP.
  - IDLE → SETUP on accept.
  - SETUP: 1 cycle; `psg_data` = byte, `psg_we_n` = 1. Then → STROBE.
  - STROBE: `WE_CYCLES` cycles; `psg_we_n` = 0; data held. Then → GAP, or → tail if `GAP_CYCLES` = 0.
  - GAP: `GAP_CYCLES` cycles; `psg_we_n` = 1; data held.
  - Tail: if H is pending → SETUP (H); else → IDLE.
- Repeated PSG sampling: the PSG samples every cycle while the strobe is low, so with `WE_CYCLES` > 1 each byte is written multiple times.
  - This is idempotent: it re-latches the same register and value.
  - For a noise write it holds the PSG's noise restart for the strobe duration.
- The internal cycle counter uses $clog2(max(WE_CYCLES, GAP_CYCLES)+1) bits and reloads on every state entry.

## Timing
- Reset values (rst_n low at an edge):
  - `psg_we_n` = 1, `psg_data` = 8'h00, `req_ready` = 0, `busy` = 0.
  - State = IDLE; shadows invalid; counter 0.
- First cycle after `rst_n` rises: `req_ready` = 1.
- For a request accepted at edge N:
  - SETUP occupies cycle N+1.
  - `psg_we_n` is low during cycles N+2 … N+1+WE_CYCLES.
- Request occupancy, from accept to the cycle `req_ready` returns high:
  - Single-byte: 1+WE_CYCLES+GAP_CYCLES cycles.
  - Two-byte: 2·(1+WE_CYCLES+GAP_CYCLES) cycles.
  - Defaults: 4 cycles single-byte, 8 cycles two-byte.
- No back-to-back accept: `req_ready` drops the cycle after acceptance.
- `psg_data` changes only on entry to SETUP or on reset; it is stable for the whole strobe and gap.
- In IDLE, `psg_data` holds the last byte.
- Reset mid-operation: at the next edge `psg_we_n` = 1 and `psg_data` = 0. The in-flight request, including any pending H, is dropped; shadows are invalidated.

## Test plan
- Tone full write, defaults: reg 000, value 10'h3A5 → bytes 8'h85 then 8'h3A. Each byte is preceded by 1 setup cycle with data stable, strobe low exactly 2 cycles, 1 gap cycle; `req_ready` is back high 8 cycles after accept.
- Shadow skip: after the previous write, reg 000, value 10'h3A7 → only 8'h87 is sent, 4 cycles total. Same request after a `flush_shadow` pulse → 8'h87, 8'h3A.
- Single-byte types: attenuation reg 011, value 5 → 8'hB5. Noise reg 110, value 10'h3FE → 8'hE6 only. Tone 1's shadow is unaffected by either.
- Parameter sweep: `WE_CYCLES`=1, `GAP_CYCLES`=0 → tone full write takes 4 cycles, with the strobe low 1 cycle per byte. `WE_CYCLES`=5, `GAP_CYCLES`=3 → 18 cycles.
- Reset mid-operation: assert `rst_n` low during the first byte's STROBE of a two-byte tone write. Required: `psg_we_n` = 1 and `psg_data` = 0 at the next edge, no H byte emitted afterward. A repeat of the same tone request after reset sends both bytes.
- Handshake hold-off: hold `req_valid` high with changing payloads. Exactly one request is accepted per IDLE visit, and each accepted payload is the one present on its accept edge.
